// File: rtl/branch_pc_unit_if.sv
// Bus bundle between the control unit and the branch/PC resolver.
// The control unit uses the master view; the resolver uses the slave view.
interface branch_pc_unit_if #(
   parameter int DATA_W = 32
);
   logic              start;
   logic [DATA_W-1:0] ir_in;
   logic [DATA_W-1:0] bus_in;
   logic              pc_inc;
   logic              pc_load_ext;
   logic [DATA_W-1:0] pc_ext_in;
   logic              busy;
   logic              done;
   logic              con_out;
   logic [DATA_W-1:0] pc_out;

   modport master (
      output start, ir_in, bus_in, pc_inc, pc_load_ext, pc_ext_in,
      input  busy, done, con_out, pc_out
   );

   modport slave (
      input  start, ir_in, bus_in, pc_inc, pc_load_ext, pc_ext_in,
      output busy, done, con_out, pc_out
   );
endinterface

// File: rtl/branch_pc_unit.sv
// Sequenced conditional-branch resolver: captures IR/Ra, evaluates CON, computes
// PC + sext(C) and commits it when CON is set. Owns the program counter.
module branch_pc_unit #(
   parameter int                DATA_W   = 32,
   parameter int                C_W      = 19,
   parameter logic [DATA_W-1:0] PC_RESET = '0
) (
   input  logic          clk,
   input  logic          clear_n,
   branch_pc_unit_if.slave br
);

   localparam int C2_LSB = 19;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      EVAL   = 2'd1,
      CALC   = 2'd2,
      UPDATE = 2'd3
   } state_t;

   state_t            state, next_state;
   logic [1:0]        c2_cap;
   logic [C_W-1:0]    c_cap;
   logic [DATA_W-1:0] ra_cap;
   logic [DATA_W-1:0] target;
   logic [DATA_W-1:0] pc_q;
   logic              con_q;
   logic              done_q;

   logic load_ext_en, capture_en, inc_en, eval_en, calc_en, update_en;

   function automatic logic cond_eval(input logic [1:0] c2, input logic [DATA_W-1:0] ra);
      logic res;
      res = 1'b0;
      case (c2)
         2'b00: res = (ra == '0);
         2'b01: res = (ra != '0);
         2'b10: res = ~ra[DATA_W-1];
         2'b11: res =  ra[DATA_W-1];
         default: res = 1'b0;
      endcase
      return res;
   endfunction

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of process ordering.
   always_ff @(posedge clk or negedge clear_n) begin
      if (!clear_n) state <= IDLE;
      else          state <= next_state;
   end

   // NOTE: defaults first so no path through the case leaves a signal unassigned
   // (otherwise a latch would be inferred).
   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (br.start && !br.pc_load_ext) next_state = EVAL;
         EVAL:    next_state = CALC;
         CALC:    next_state = UPDATE;
         UPDATE:  next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Requests in IDLE resolve as pc_load_ext > start > pc_inc; losers are dropped.
   always_comb begin
      load_ext_en = 1'b0;
      capture_en  = 1'b0;
      inc_en      = 1'b0;
      eval_en     = 1'b0;
      calc_en     = 1'b0;
      update_en   = 1'b0;
      case (state)
         IDLE: begin
            load_ext_en = br.pc_load_ext;
            capture_en  = br.start  && !br.pc_load_ext;
            inc_en      = br.pc_inc && !br.start && !br.pc_load_ext;
         end
         EVAL:    eval_en   = 1'b1;
         CALC:    calc_en   = 1'b1;
         UPDATE:  update_en = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge clear_n) begin
      if (!clear_n) begin
         c2_cap <= '0;
         c_cap  <= '0;
         ra_cap <= '0;
         target <= '0;
         pc_q   <= PC_RESET;
         con_q  <= 1'b0;
         done_q <= 1'b0;
      end else begin
         done_q <= update_en;
         if (capture_en) begin
            c2_cap <= br.ir_in[C2_LSB+1:C2_LSB];
            c_cap  <= br.ir_in[C_W-1:0];
            ra_cap <= br.bus_in;
         end
         if (eval_en) con_q  <= cond_eval(c2_cap, ra_cap);
         if (calc_en) target <= pc_q + {{(DATA_W-C_W){c_cap[C_W-1]}}, c_cap};
         if (load_ext_en)            pc_q <= br.pc_ext_in;
         else if (inc_en)            pc_q <= pc_q + DATA_W'(1);
         else if (update_en && con_q) pc_q <= target;
      end
   end

   assign br.busy    = (state != IDLE);
   assign br.done    = done_q;
   assign br.con_out = con_q;
   assign br.pc_out  = pc_q;

endmodule

// File: tb/tb_branch_pc_unit.sv
// Self-checking bench for branch_pc_unit: directed scenarios plus randomized
// traffic, checked against a plain-arithmetic reference of PC and CON.
module tb_branch_pc_unit;

   localparam int          DATA_W   = 32;
   localparam int          C_W      = 19;
   localparam logic [31:0] PC_RESET = 32'h0;

   logic clk;
   logic clear_n;
   int   n_checks;
   int   n_fail;

   logic [31:0] exp_pc;
   logic        exp_con;

   branch_pc_unit_if #(.DATA_W(DATA_W)) bif ();

   branch_pc_unit #(
      .DATA_W  (DATA_W),
      .C_W     (C_W),
      .PC_RESET(PC_RESET)
   ) dut (
      .clk    (clk),
      .clear_n(clear_n),
      .br     (bif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: condition on Ra treated as a signed integer.
   function automatic logic cond_ref(input logic [1:0] c2, input logic [31:0] ra);
      case (c2)
         2'd0:    return ra == 0;
         2'd1:    return ra != 0;
         2'd2:    return $signed(ra) >= 0;
         default: return $signed(ra) < 0;
      endcase
   endfunction

   function automatic logic [31:0] target_ref(input logic [31:0] pc, input logic [18:0] c);
      longint off;
      off = longint'(c);
      if (off >= 64'sd262144) off = off - 64'sd524288;
      return 32'(longint'(pc) + off);
   endfunction

   function automatic logic [31:0] mk_ir(input logic [1:0] c2, input logic [18:0] c);
      logic [31:0] ir;
      ir        = $urandom;
      ir[20:19] = c2;
      ir[18:0]  = c;
      return ir;
   endfunction

   task automatic idle_inputs();
      bif.start       = 1'b0;
      bif.pc_inc      = 1'b0;
      bif.pc_load_ext = 1'b0;
   endtask

   // One IDLE-edge request; load > start > inc.
   task automatic idle_op(input logic ld, input logic st, input logic inc, input logic [31:0] val);
      @(negedge clk);
      bif.pc_load_ext = ld;
      bif.start       = st;
      bif.pc_inc      = inc;
      bif.pc_ext_in   = val;
      @(posedge clk);
      @(negedge clk);
      idle_inputs();
      if (ld)        exp_pc = val;
      else if (!st && inc) exp_pc = exp_pc + 1;
      check("idle_pc", bif.pc_out, exp_pc);
      if (ld) check("idle_no_branch", bif.busy, 1'b0);
   endtask

   // Full branch; with noise, requests and operands toggle while busy.
   task automatic run_branch(input string tag, input logic [1:0] c2, input logic [18:0] c,
                             input logic [31:0] ra, input bit noise);
      int          lat;
      logic [31:0] pc0;
      @(negedge clk);
      bif.ir_in       = mk_ir(c2, c);
      bif.bus_in      = ra;
      bif.start       = 1'b1;
      bif.pc_load_ext = 1'b0;
      bif.pc_inc      = noise;
      pc0             = exp_pc;
      lat             = 0;
      while (1) begin
         @(posedge clk);
         @(negedge clk);
         lat++;
         if (bif.done || lat >= 8) break;
         if (lat == 1) check({tag, "_busy"}, bif.busy, 1'b1);
         bif.start = noise ? 1'($urandom) : 1'b0;
         if (noise) begin
            bif.pc_inc      = 1'b1;
            bif.pc_load_ext = 1'($urandom);
            bif.pc_ext_in   = $urandom;
            bif.ir_in       = $urandom;
            bif.bus_in      = $urandom;
         end
      end
      idle_inputs();
      exp_con = cond_ref(c2, ra);
      if (exp_con) exp_pc = target_ref(pc0, c);
      check({tag, "_latency"}, 64'(lat), 64'd4);
      check({tag, "_busy_end"}, bif.busy, 1'b0);
      check({tag, "_con"}, bif.con_out, exp_con);
      check({tag, "_pc"}, bif.pc_out, exp_pc);
      @(posedge clk);
      @(negedge clk);
      check({tag, "_done_pulse"}, bif.done, 1'b0);
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      clear_n  = 1'b0;
      idle_inputs();
      bif.ir_in     = '0;
      bif.bus_in    = '0;
      bif.pc_ext_in = '0;
      exp_pc  = PC_RESET;
      exp_con = 1'b0;

      #12;
      check("rst_pc", bif.pc_out, PC_RESET);
      check("rst_busy", bif.busy, 1'b0);
      check("rst_done", bif.done, 1'b0);
      check("rst_con", bif.con_out, 1'b0);
      @(negedge clk);
      clear_n = 1'b1;

      // brzr taken
      idle_op(1'b1, 1'b0, 1'b0, 32'h10);
      run_branch("brzr", 2'b00, 19'h00005, 32'h0, 1'b0);
      check("brzr_pc_const", bif.pc_out, 32'h15);

      // brnz not taken
      idle_op(1'b1, 1'b0, 1'b0, 32'h20);
      run_branch("brnz", 2'b01, 19'h7FFFF, 32'h0, 1'b0);
      check("brnz_pc_const", bif.pc_out, 32'h20);

      // brmi backward wrap
      idle_op(1'b1, 1'b0, 1'b0, 32'h2);
      run_branch("brmi", 2'b11, 19'h7FFFC, 32'h8000_0000, 1'b0);
      check("brmi_pc_const", bif.pc_out, 32'hFFFF_FFFE);

      // load beats start; then a branch with pc_inc asserted throughout busy
      idle_op(1'b1, 1'b1, 1'b0, 32'h100);
      check("prio_pc_const", bif.pc_out, 32'h100);
      idle_op(1'b0, 1'b1, 1'b1, 32'h0);
      check("prio_start_no_inc", bif.pc_out, 32'h100);
      @(negedge clk);
      check("prio_start_busy", bif.busy, 1'b1);
      repeat (3) @(negedge clk);
      idle_inputs();
      exp_con = cond_ref(bif.ir_in[20:19], bif.bus_in);
      if (exp_con) exp_pc = target_ref(32'h100, bif.ir_in[18:0]);
      check("prio_drop_pc", bif.pc_out, exp_pc);
      idle_op(1'b0, 1'b0, 1'b1, 32'h0);
      run_branch("lockout", 2'b00, 19'h00040, 32'h0, 1'b1);

      // reset during CALC of a taken brpl
      @(negedge clk);
      bif.ir_in  = mk_ir(2'b10, 19'h00100);
      bif.bus_in = 32'h1;
      bif.start  = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bif.start = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("rstmid_con_before", bif.con_out, 1'b1);
      clear_n = 1'b0;
      #1;
      exp_pc  = PC_RESET;
      exp_con = 1'b0;
      check("rstmid_pc", bif.pc_out, exp_pc);
      check("rstmid_busy", bif.busy, 1'b0);
      check("rstmid_con", bif.con_out, 1'b0);
      @(negedge clk);
      clear_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("rstmid_no_done", bif.done, 1'b0);
      end
      check("rstmid_pc_after", bif.pc_out, exp_pc);

      // back-to-back with start held high; fresh operands at each IDLE entry
      begin
         logic [1:0]  c2;
         logic [18:0] c;
         logic [31:0] ra;
         logic [31:0] pc0;
         idle_op(1'b1, 1'b0, 1'b0, 32'h4000);
         @(negedge clk);
         c2 = 2'($urandom); c = 19'($urandom); ra = ($urandom % 2) ? 32'h0 : $urandom;
         bif.ir_in  = mk_ir(c2, c);
         bif.bus_in = ra;
         bif.start  = 1'b1;
         for (int b = 0; b < 4; b++) begin
            pc0 = exp_pc;
            for (int k = 1; k <= 4; k++) begin
               @(posedge clk);
               @(negedge clk);
               if (k == 1) begin
                  bif.ir_in  = $urandom;
                  bif.bus_in = $urandom;
               end
               check("b2b_done", bif.done, 1'(k == 4));
               check("b2b_busy", bif.busy, 1'(k != 4));
            end
            exp_con = cond_ref(c2, ra);
            if (exp_con) exp_pc = target_ref(pc0, c);
            check("b2b_con", bif.con_out, exp_con);
            check("b2b_pc", bif.pc_out, exp_pc);
            c2 = 2'($urandom); c = 19'($urandom); ra = ($urandom % 2) ? 32'h0 : $urandom;
            bif.ir_in  = mk_ir(c2, c);
            bif.bus_in = ra;
         end
         bif.start = 1'b0;
         @(posedge clk);
         @(negedge clk);
         check("b2b_stop", bif.busy, 1'b0);
      end

      // randomized mix of fetch increments, jumps and branches
      for (int i = 0; i < 24; i++) begin
         logic [31:0] ra;
         case ($urandom_range(0, 3))
            0: idle_op(1'b0, 1'b0, 1'b1, 32'h0);
            1: idle_op(1'b1, 1'($urandom), 1'($urandom), $urandom);
            2: run_branch("rnd", 2'($urandom), 19'($urandom), $urandom, 1'($urandom));
            default: begin
               ra = ($urandom % 2) ? 32'h0 : {1'($urandom), 31'h0};
               run_branch("rnd_edge", 2'($urandom), 19'($urandom), ra, 1'b0);
            end
         endcase
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
